// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus: issue, writeback, operand query and commit signals.
//   master : instruction issue / CDB / register-file side (drives requests)
//   slave  : the reorder buffer itself
// Signals
//   issue_valid/has_rd/rd -> ; issue_ready/issue_tag <-
//   wb_valid/tag/data ->      (common data bus writeback)
//   qry_tag_1/2 ->           ; qry_ready_1/2, qry_data_1/2 <-  (forwarding)
//   commit_signal/rd_tag/rd_data <-                           (rf commit port)
//   count <-                                                  (occupancy)
interface reorder_buffer_if #(
  parameter int unsigned ROB_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_WIDTH  = 5
);
  logic                  issue_valid;
  logic                  issue_has_rd;
  logic [REG_WIDTH-1:0]  issue_rd;
  logic                  issue_ready;
  logic [ROB_WIDTH-1:0]  issue_tag;

  logic                  wb_valid;
  logic [ROB_WIDTH-1:0]  wb_tag;
  logic [DATA_WIDTH-1:0] wb_data;

  logic [ROB_WIDTH-1:0]  qry_tag_1;
  logic [ROB_WIDTH-1:0]  qry_tag_2;
  logic                  qry_ready_1;
  logic                  qry_ready_2;
  logic [DATA_WIDTH-1:0] qry_data_1;
  logic [DATA_WIDTH-1:0] qry_data_2;

  logic                  commit_signal;
  logic [ROB_WIDTH-1:0]  commit_rd_tag;
  logic [DATA_WIDTH-1:0] commit_rd_data;
  logic [ROB_WIDTH:0]    count;

  modport master (
    output issue_valid, issue_has_rd, issue_rd, wb_valid, wb_tag, wb_data,
           qry_tag_1, qry_tag_2,
    input  issue_ready, issue_tag, qry_ready_1, qry_ready_2, qry_data_1, qry_data_2,
           commit_signal, commit_rd_tag, commit_rd_data, count
  );

  modport slave (
    input  issue_valid, issue_has_rd, issue_rd, wb_valid, wb_tag, wb_data,
           qry_tag_1, qry_tag_2,
    output issue_ready, issue_tag, qry_ready_1, qry_ready_2, qry_data_1, qry_data_2,
           commit_signal, commit_rd_tag, commit_rd_data, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer scheduling the register file's single commit port.
// Allocates tags at issue, collects out-of-order writebacks, retires in program
// order (one per cycle) and forwards done-but-uncommitted results to issue.
// Ports
//   clk_in   : clock
//   rst_in   : asynchronous active-high reset
//   rdy_in   : global ready; low freezes all state (flush still acts)
//   flush_in : discard all entries
//   rob      : reorder_buffer_if slave (issue / writeback / query / commit / count)
module reorder_buffer #(
  parameter int unsigned ROB_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_WIDTH  = 5
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           flush_in,
  reorder_buffer_if.slave rob
);
  localparam int unsigned DEPTH = 2 ** ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] FULL_COUNT = (ROB_WIDTH + 1)'(DEPTH);

  logic [DEPTH-1:0]      busy_q, done_q, has_rd_q;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [ROB_WIDTH-1:0]  head_q, head_d, tail_q, tail_d;
  logic [ROB_WIDTH:0]    count_q, count_d;

  logic                  commit_signal_q;
  logic [ROB_WIDTH-1:0]  commit_tag_q;
  logic [DATA_WIDTH-1:0] commit_data_q;

  logic issue_fire, wb_fire, commit_fire;

  assign rob.issue_ready    = (count_q != FULL_COUNT);
  assign rob.issue_tag      = tail_q;
  assign rob.count          = count_q;
  assign rob.commit_signal  = commit_signal_q;
  assign rob.commit_rd_tag  = commit_tag_q;
  assign rob.commit_rd_data = commit_data_q;

  assign issue_fire  = rdy_in & rob.issue_valid & rob.issue_ready;
  // The slot at tail is never busy while not full; the explicit tag check keeps a
  // writeback from ever touching the entry being allocated this cycle.
  assign wb_fire     = rdy_in & rob.wb_valid & busy_q[rob.wb_tag] &
                       ~(issue_fire & (rob.wb_tag == tail_q));
  assign commit_fire = rdy_in & busy_q[head_q] & done_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (issue_fire)  tail_d = tail_q + ROB_WIDTH'(1);
    if (commit_fire) head_d = head_q + ROB_WIDTH'(1);
    case ({issue_fire, commit_fire})
      2'b10:   count_d = count_q + (ROB_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (ROB_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      busy_q          <= '0;
      done_q          <= '0;
      has_rd_q        <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      commit_signal_q <= 1'b0;
      commit_tag_q    <= '0;
      commit_data_q   <= '0;
    end else if (flush_in) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      busy_q          <= '0;
      done_q          <= '0;
      commit_signal_q <= 1'b0;
    end else if (rdy_in) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (issue_fire) begin
        busy_q[tail_q]   <= 1'b1;
        done_q[tail_q]   <= 1'b0;
        has_rd_q[tail_q] <= rob.issue_has_rd & (rob.issue_rd != REG_WIDTH'(0));
      end
      if (wb_fire) begin
        done_q[rob.wb_tag] <= 1'b1;
        data_q[rob.wb_tag] <= rob.wb_data;
      end
      if (commit_fire) begin
        busy_q[head_q]  <= 1'b0;
        commit_signal_q <= has_rd_q[head_q];
        commit_tag_q    <= head_q;
        commit_data_q   <= data_q[head_q];
      end else begin
        commit_signal_q <= 1'b0;
      end
    end
  end

  // Forwarding: a same-cycle CDB result wins over the stored entry.
  always_comb begin
    rob.qry_ready_1 = 1'b0;
    rob.qry_data_1  = '0;
    rob.qry_ready_2 = 1'b0;
    rob.qry_data_2  = '0;
    if (busy_q[rob.qry_tag_1]) begin
      if (rob.wb_valid && (rob.wb_tag == rob.qry_tag_1)) begin
        rob.qry_ready_1 = 1'b1;
        rob.qry_data_1  = rob.wb_data;
      end else begin
        rob.qry_ready_1 = done_q[rob.qry_tag_1];
        rob.qry_data_1  = data_q[rob.qry_tag_1];
      end
    end
    if (busy_q[rob.qry_tag_2]) begin
      if (rob.wb_valid && (rob.wb_tag == rob.qry_tag_2)) begin
        rob.qry_ready_2 = 1'b1;
        rob.qry_data_2  = rob.wb_data;
      end else begin
        rob.qry_ready_2 = done_q[rob.qry_tag_2];
        rob.qry_data_2  = data_q[rob.qry_tag_2];
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: in-order commit, full/wrap, forwarding,
// silent retirement, stall hold, flush and asynchronous reset.
module tb_reorder_buffer;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush_in;
  int   checks = 0;
  int   errors = 0;

  reorder_buffer_if #(.ROB_WIDTH(4), .DATA_WIDTH(32), .REG_WIDTH(5)) bus ();

  reorder_buffer #(.ROB_WIDTH(4), .DATA_WIDTH(32), .REG_WIDTH(5)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush_in (flush_in),
    .rob      (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and checks happen 1 time unit after it.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic has_rd, input logic [4:0] rd);
    bus.issue_valid  = 1'b1;
    bus.issue_has_rd = has_rd;
    bus.issue_rd     = rd;
    tick();
    bus.issue_valid  = 1'b0;
  endtask

  task automatic wb(input logic [3:0] tag, input logic [31:0] data);
    bus.wb_valid = 1'b1;
    bus.wb_tag   = tag;
    bus.wb_data  = data;
    tick();
    bus.wb_valid = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_has_rd = 1'b0; bus.issue_rd = '0;
    bus.wb_valid = 1'b0; bus.wb_tag = '0; bus.wb_data = '0;
    bus.qry_tag_1 = '0; bus.qry_tag_2 = '0;
    #2;
    chk("rst_count", bus.count, 0);
    chk("rst_issue_ready", bus.issue_ready, 1);
    chk("rst_issue_tag", bus.issue_tag, 0);
    chk("rst_commit_signal", bus.commit_signal, 0);
    chk("rst_commit_tag", bus.commit_rd_tag, 0);
    chk("rst_commit_data", bus.commit_rd_data, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // Three ops with rd 1,2,3 get tags 0,1,2.
    for (int i = 0; i < 3; i++) begin
      chk("issue_tag_seq", bus.issue_tag, i);
      issue(1'b1, 5'(i + 1));
    end
    chk("count_3", bus.count, 3);
    chk("no_commit_pre_wb", bus.commit_signal, 0);
    tick();
    chk("no_commit_idle", bus.commit_signal, 0);

    // Out-of-order writeback, in-order commit.
    wb(4'd2, 32'h22);
    chk("no_commit_tag2_only", bus.commit_signal, 0);
    wb(4'd0, 32'h00);
    chk("tag0_not_yet_retired", bus.commit_signal, 0);
    wb(4'd1, 32'h11);
    chk("c0_sig", bus.commit_signal, 1);
    chk("c0_tag", bus.commit_rd_tag, 0);
    chk("c0_data", bus.commit_rd_data, 32'h00);
    chk("c0_count", bus.count, 2);
    tick();
    chk("c1_sig", bus.commit_signal, 1);
    chk("c1_tag", bus.commit_rd_tag, 1);
    chk("c1_data", bus.commit_rd_data, 32'h11);
    chk("c1_count", bus.count, 1);
    tick();
    chk("c2_sig", bus.commit_signal, 1);
    chk("c2_tag", bus.commit_rd_tag, 2);
    chk("c2_data", bus.commit_rd_data, 32'h22);
    chk("c2_count", bus.count, 0);
    tick();
    chk("empty_no_commit", bus.commit_signal, 0);
    chk("empty_count", bus.count, 0);
    chk("tail_after_3", bus.issue_tag, 3);

    // Flush to realign tags to 0, then fill all 16 entries.
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk("realign_tag", bus.issue_tag, 0);
    for (int i = 0; i < 16; i++) issue(1'b1, 5'd7);
    chk("full_count", bus.count, 16);
    chk("full_not_ready", bus.issue_ready, 0);
    chk("full_tag_wrap", bus.issue_tag, 0);
    issue(1'b1, 5'd8);
    chk("17th_ignored_count", bus.count, 16);
    chk("17th_ignored_tag", bus.issue_tag, 0);

    // Retire one: slot reopens only after the commit edge.
    wb(4'd0, 32'h55);
    chk("wb_edge_still_full", bus.issue_ready, 0);
    tick();
    chk("retire_sig", bus.commit_signal, 1);
    chk("retire_data", bus.commit_rd_data, 32'h55);
    chk("retire_count", bus.count, 15);
    chk("reopen_ready", bus.issue_ready, 1);
    chk("reopen_tag", bus.issue_tag, 0);
    issue(1'b1, 5'd3);
    chk("refull_count", bus.count, 16);
    chk("refull_not_ready", bus.issue_ready, 0);

    // Forwarding from the CDB in the same cycle, then from the stored entry.
    bus.qry_tag_1 = 4'd5;
    bus.qry_tag_2 = 4'd6;
    bus.wb_valid = 1'b1; bus.wb_tag = 4'd5; bus.wb_data = 32'hABCD;
    #1;
    chk("fwd_cdb_ready", bus.qry_ready_1, 1);
    chk("fwd_cdb_data", bus.qry_data_1, 32'hABCD);
    chk("qry_busy_not_done", bus.qry_ready_2, 0);
    @(posedge clk_in); #1;
    bus.wb_valid = 1'b0;
    #1;
    chk("fwd_entry_ready", bus.qry_ready_1, 1);
    chk("fwd_entry_data", bus.qry_data_1, 32'hABCD);

    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk("flush_full_count", bus.count, 0);
    chk("qry_nonbusy_ready", bus.qry_ready_1, 0);
    chk("qry_nonbusy_data", bus.qry_data_1, 0);

    // Entries without a destination retire silently.
    issue(1'b0, 5'd4);
    issue(1'b1, 5'd0);
    wb(4'd0, 32'h1);
    wb(4'd1, 32'h2);
    chk("silent0_sig", bus.commit_signal, 0);
    chk("silent0_count", bus.count, 1);
    tick();
    chk("silent1_sig", bus.commit_signal, 0);
    chk("silent1_tag", bus.commit_rd_tag, 1);
    chk("silent1_count", bus.count, 0);

    // Stall with a commit pending on the rf port.
    issue(1'b1, 5'd9);
    wb(4'd2, 32'h77);
    tick();
    chk("pre_stall_sig", bus.commit_signal, 1);
    chk("pre_stall_tag", bus.commit_rd_tag, 2);
    rdy_in = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_has_rd = 1'b1; bus.issue_rd = 5'd10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_sig", bus.commit_signal, 1);
      chk("stall_data", bus.commit_rd_data, 32'h77);
      chk("stall_count", bus.count, 0);
      chk("stall_tag", bus.issue_tag, 3);
    end
    bus.issue_valid = 1'b0;
    rdy_in = 1'b1;
    tick();
    chk("no_double_retire", bus.commit_signal, 0);
    chk("post_stall_count", bus.count, 0);

    // Flush with 4 busy entries, while stalled and issuing.
    for (int i = 0; i < 4; i++) issue(1'b1, 5'(i + 1));
    chk("four_busy", bus.count, 4);
    rdy_in = 1'b0; flush_in = 1'b1; bus.issue_valid = 1'b1;
    tick();
    flush_in = 1'b0; bus.issue_valid = 1'b0; rdy_in = 1'b1;
    chk("flush4_count", bus.count, 0);
    chk("flush4_tag", bus.issue_tag, 0);
    chk("flush4_sig", bus.commit_signal, 0);
    issue(1'b1, 5'd1);
    chk("post_flush_count", bus.count, 1);
    chk("post_flush_tag", bus.issue_tag, 1);

    // Asynchronous reset mid-operation.
    #2;
    rst_in = 1'b1;
    #1;
    chk("async_rst_count", bus.count, 0);
    chk("async_rst_tag", bus.issue_tag, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
